// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock LSB first,
// using a single full-subtractor cell and a registered borrow.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [WIDTH-1:0] res_full;
  logic [WIDTH-1:0] diff_r;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             done_r;
  logic             bout_r;
  logic             ovf_r;
  logic             a_i;
  logic             b_i;
  logic             d_i;
  logic             br_next;
  logic             last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = SHIFT;
      SHIFT:   if (last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Full-subtractor cell; res_full is the completed result on the final edge.
  always_comb begin
    a_i      = a_sh[0];
    b_i      = b_sh[0];
    d_i      = a_i ^ b_i ^ br;
    br_next  = (~a_i & b_i) | (~(a_i ^ b_i) & br);
    last     = (cnt == LAST);
    res_full = {d_i, res_sh};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      diff_r <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      done_r <= 1'b0;
      bout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          a_sh <= bus.a;
          b_sh <= bus.b;
          br   <= bus.bin;
          cnt  <= '0;
        end
      end else begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        res_sh <= res_full[WIDTH-1:1];
        br     <= br_next;
        if (!last) begin
          cnt <= cnt + CNT_W'(1);
        end else begin
          // Outputs change only here, so callers never see partial results.
          diff_r <= res_full;
          bout_r <= br_next;
          ovf_r  <= br ^ br_next;
          done_r <= 1'b1;
        end
      end
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = done_r;
  assign bus.diff = diff_r;
  assign bus.bout = bout_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed vectors at WIDTH=8 plus
// random operations against an arithmetic reference at WIDTH=8 and WIDTH=13.
module tb_serial_subtractor;

  typedef struct {
    logic [63:0] diff;
    logic        bout;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;

  int compared   = 0;
  int mismatched = 0;

  exp_t q8[$];
  exp_t q13[$];

  serial_subtractor_if #(.WIDTH(8))  bus8 ();
  serial_subtractor_if #(.WIDTH(13)) bus13 ();

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_subtractor #(.WIDTH(13)) dut13 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic exp_t refModel(input int w, input logic [63:0] a, input logic [63:0] b, input logic bin);
    exp_t        e;
    logic [64:0] full;
    logic [63:0] mask;
    mask   = (64'd1 << w) - 64'd1;
    full   = {1'b0, a} - {1'b0, b} - 65'(bin);
    e.diff = full[63:0] & mask;
    e.bout = ({1'b0, a} < ({1'b0, b} + 65'(bin)));
    e.ovf  = (a[w-1] != b[w-1]) && (e.diff[w-1] != a[w-1]);
    return e;
  endfunction

  // Presents one request at the current negedge, queues its expected result,
  // then drops start and scrambles the operands after the accepting edge.
  task automatic applyStimulus(input int sel, input logic [63:0] a, input logic [63:0] b, input logic bin,
                               input logic [63:0] ed, input logic eb, input logic eo);
    exp_t e;
    e.diff = ed;
    e.bout = eb;
    e.ovf  = eo;
    if (sel == 8) begin
      bus8.start = 1'b1;
      bus8.a     = a[7:0];
      bus8.b     = b[7:0];
      bus8.bin   = bin;
      q8.push_back(e);
    end else begin
      bus13.start = 1'b1;
      bus13.a     = a[12:0];
      bus13.b     = b[12:0];
      bus13.bin   = bin;
      q13.push_back(e);
    end
    @(negedge clk);
    bus8.start  = 1'b0;
    bus13.start = 1'b0;
    bus8.a      = 8'($urandom);
    bus8.b      = 8'($urandom);
    bus8.bin    = 1'($urandom);
    bus13.a     = 13'($urandom);
    bus13.b     = 13'($urandom);
    bus13.bin   = 1'($urandom);
  endtask

  task automatic waitDone(input int sel);
    int   n;
    logic d;
    n = 0;
    d = (sel == 8) ? bus8.done : bus13.done;
    while (!d && n < 100) begin
      @(negedge clk);
      n++;
      d = (sel == 8) ? bus8.done : bus13.done;
    end
    checkOutput("done_seen", 64'(d), 64'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus8.done) begin
      if (q8.size() == 0) begin
        checkOutput("unexpected_done8", 64'd1, 64'd0);
      end else begin
        e = q8.pop_front();
        checkOutput("diff8", 64'(bus8.diff), e.diff);
        checkOutput("bout8", 64'(bus8.bout), 64'(e.bout));
        checkOutput("ovf8",  64'(bus8.ovf),  64'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus13.done) begin
      if (q13.size() == 0) begin
        checkOutput("unexpected_done13", 64'd1, 64'd0);
      end else begin
        e = q13.pop_front();
        checkOutput("diff13", 64'(bus13.diff), e.diff);
        checkOutput("bout13", 64'(bus13.bout), 64'(e.bout));
        checkOutput("ovf13",  64'(bus13.ovf),  64'(e.ovf));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          n;
    exp_t        e;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rbin;

    rst_n       = 1'b0;
    bus8.start  = 1'b0;
    bus8.a      = '0;
    bus8.b      = '0;
    bus8.bin    = 1'b0;
    bus13.start = 1'b0;
    bus13.a     = '0;
    bus13.b     = '0;
    bus13.bin   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 64'(bus8.busy), 64'd0);
    checkOutput("rst_done", 64'(bus8.done), 64'd0);
    checkOutput("rst_diff", 64'(bus8.diff), 64'd0);
    checkOutput("rst_bout", 64'(bus8.bout), 64'd0);
    checkOutput("rst_ovf",  64'(bus8.ovf),  64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic 100 - 37 with latency check");
    applyStimulus(8, 64'd100, 64'd37, 1'b0, 64'h3F, 1'b0, 1'b0);
    n = 0;
    while (bus8.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busy_cycles", 64'(n), 64'd8);
    checkOutput("done_latency", 64'(bus8.done), 64'd1);
    @(negedge clk);
    checkOutput("done_one_cycle", 64'(bus8.done), 64'd0);

    $display("[TB] borrow and overflow boundaries");
    applyStimulus(8, 64'h00, 64'h01, 1'b0, 64'hFF, 1'b1, 1'b0);
    waitDone(8);
    applyStimulus(8, 64'h80, 64'h01, 1'b0, 64'h7F, 1'b0, 1'b1);
    waitDone(8);

    $display("[TB] borrow-in with result hold during busy");
    applyStimulus(8, 64'h05, 64'h05, 1'b1, 64'hFF, 1'b1, 1'b0);
    n = 0;
    while (bus8.busy && n < 20) begin
      checkOutput("diff_hold", 64'(bus8.diff), 64'h7F);
      checkOutput("ovf_hold",  64'(bus8.ovf),  64'd1);
      @(negedge clk);
      n++;
    end
    waitDone(8);

    $display("[TB] start while busy ignored, back-to-back start in done cycle");
    applyStimulus(8, 64'h3C, 64'h0F, 1'b0, 64'h2D, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = 8'hFF;
    bus8.b     = 8'h00;
    @(negedge clk);
    bus8.start = 1'b0;
    waitDone(8);
    applyStimulus(8, 64'h9A, 64'h23, 1'b1, 64'h76, 1'b0, 1'b1);
    n = 1;
    while (!bus8.done && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("b2b_spacing", 64'(n), 64'd9);

    $display("[TB] reset asserted mid-operation");
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = 8'hAA;
    bus8.b     = 8'h55;
    bus8.bin   = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 64'(bus8.busy), 64'd0);
    checkOutput("midrst_done", 64'(bus8.done), 64'd0);
    checkOutput("midrst_diff", 64'(bus8.diff), 64'd0);
    checkOutput("midrst_bout", 64'(bus8.bout), 64'd0);
    checkOutput("midrst_ovf",  64'(bus8.ovf),  64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("post_rst_busy", 64'(bus8.busy), 64'd0);
    applyStimulus(8, 64'h10, 64'h01, 1'b0, 64'h0F, 1'b0, 1'b0);
    waitDone(8);

    $display("[TB] random operations, WIDTH=8");
    for (int i = 0; i < 1000; i++) begin
      ra   = 64'($urandom_range(255, 0));
      rb   = 64'($urandom_range(255, 0));
      rbin = 1'($urandom);
      e    = refModel(8, ra, rb, rbin);
      applyStimulus(8, ra, rb, rbin, e.diff, e.bout, e.ovf);
      waitDone(8);
    end

    $display("[TB] random operations, WIDTH=13");
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      ra   = 64'($urandom_range(8191, 0));
      rb   = 64'($urandom_range(8191, 0));
      rbin = 1'($urandom);
      e    = refModel(13, ra, rb, rbin);
      applyStimulus(13, ra, rb, rbin, e.diff, e.bout, e.ovf);
      waitDone(13);
    end

    repeat (3) @(negedge clk);
    checkOutput("q8_drained",  64'(q8.size()),  64'd0);
    checkOutput("q13_drained", 64'(q13.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
